// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port sync data RAM between CPU (port 0) and debug/loader (port 1).
// Ack arrives 2 cycles after the request edge; a master waits by holding req until its ack pulse.
module dmem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t              state, state_nxt;
  logic                win, win_nxt;
  logic                last_grant, last_grant_nxt;
  logic                cmd_we, cmd_we_nxt;
  logic [ADDR_W-1:0]   cmd_addr, cmd_addr_nxt;
  logic [DATA_W-1:0]   cmd_wdata, cmd_wdata_nxt;
  logic                grab;
  logic                grab_port;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      win        <= 1'b0;
      last_grant <= 1'b1;
      cmd_we     <= 1'b0;
      cmd_addr   <= '0;
      cmd_wdata  <= '0;
    end else begin
      state      <= state_nxt;
      win        <= win_nxt;
      last_grant <= last_grant_nxt;
      cmd_we     <= cmd_we_nxt;
      cmd_addr   <= cmd_addr_nxt;
      cmd_wdata  <= cmd_wdata_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    win_nxt        = win;
    last_grant_nxt = last_grant;
    cmd_we_nxt     = cmd_we;
    cmd_addr_nxt   = cmd_addr;
    cmd_wdata_nxt  = cmd_wdata;
    grab           = 1'b0;
    grab_port      = 1'b0;
    m0_ack         = 1'b0;
    m1_ack         = 1'b0;
    m0_rdata       = '0;
    m1_rdata       = '0;

    case (state)
      IDLE: begin
        grab      = m0_req | m1_req;
        grab_port = (m0_req & m1_req) ? ~last_grant : m1_req;
      end
      ISSUE: state_nxt = RESP;
      RESP: begin
        m0_ack   = ~win;
        m1_ack   = win;
        m0_rdata = (!win && !cmd_we) ? mem_rdata : '0;
        m1_rdata = ( win && !cmd_we) ? mem_rdata : '0;
        // The winner's req still belongs to the transaction being acked; only the other port may chain.
        grab      = win ? m0_req : m1_req;
        grab_port = ~win;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (grab) begin
      state_nxt      = ISSUE;
      win_nxt        = grab_port;
      last_grant_nxt = grab_port;
      cmd_we_nxt     = grab_port ? m1_we    : m0_we;
      cmd_addr_nxt   = grab_port ? m1_addr  : m0_addr;
      cmd_wdata_nxt  = grab_port ? m1_wdata : m0_wdata;
    end
  end

  assign mem_en    = (state == ISSUE);
  assign mem_we    = (state == ISSUE) && cmd_we;
  assign mem_addr  = cmd_addr;
  assign mem_wdata = cmd_wdata;
  assign busy      = (state != IDLE);

endmodule
